test_frame_scheduler: RTL and testbench
=======================================

# test_frame_scheduler

Sequencer that sources back-to-back test Ethernet frames (header + counting-pattern payload) into the eth TX path, for end-to-end link checking against the team's test receiver. It starts on a software/VIO start pulse, emits a programmable number of frames with a programmable inter-frame gap, and reports progress counters. It sits between the control/debug register block and the eth frame TX interface.

## Interface
- LENGTH, 512: payload beats per frame (≥2).
- LOCAL_MAC, 48'h02_00_00_00_00_00: value driven on m_eth_src_mac.
- DST_MAC, 48'h02_00_00_00_00_00: value driven on m_eth_dest_mac.
- ETH_TYPE, 16'h88B5: value driven on m_eth_type.
- DATA_WIDTH, 8: payload width in bits (8..32).
- GAP_WIDTH, 16: width of the gap setting.

- clk  in  1  single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  one-cycle pulse; ends the run after the current frame.
- frame_limit  in  32  frames per run; 0 = unlimited; sampled on accepted start.
- gap_cycles  in  GAP_WIDTH  idle cycles between tlast handshake and next header; sampled on accepted start.
- busy  out  1  high while a run is active.
- frames_sent  out  32  frames completed in the current run.
- beats_sent  out  32  payload beats sent since reset (not cleared by start).
- m_eth_hdr_valid / m_eth_hdr_ready  out/in  1  header handshake.
- m_eth_dest_mac, m_eth_src_mac  out  48  constant DST_MAC / LOCAL_MAC.
- m_eth_type  out  16  constant ETH_TYPE.
- m_eth_payload_axis_tdata  out  DATA_WIDTH  beats_sent[DATA_WIDTH-1:0].
- m_eth_payload_axis_tvalid / tready  out/in  1  payload handshake.
- m_eth_payload_axis_tlast  out  1  high on beat LENGTH-1 of the frame.
- m_eth_payload_axis_tuser  out  1  tied 0.

## Operation
- States: IDLE, HDR, PAYLOAD, GAP.
- IDLE: start → latch frame_limit, gap_cycles; clear frames_sent, stop_pending; → HDR. stop in IDLE ignored.
- HDR: hdr_valid=1 until hdr fire → PAYLOAD, frame beat counter := 0.
- PAYLOAD: tvalid=1; on each fire beats_sent++, frame beat counter++; tlast when frame beat counter == LENGTH-1. On tlast fire frames_sent++, then: stop_pending or (limit≠0 and frames_sent+1 == limit) → IDLE; else gap==0 → HDR; else → GAP.
- GAP: count gap_cycles cycles, then → HDR.
- stop while busy sets stop_pending; frame in flight always completes (never truncated). stop coincident with tlast fire ends the run at that frame.
- start while busy ignored; start and stop in the same IDLE cycle: start wins, stop ignored.
- tdata/tlast/hdr fields stable while valid and not ready (AXI-S rule); valid never drops without handshake.
- beats_sent, frames_sent wrap modulo 2^32; tdata pattern continues across frames and runs.

## Timing
- Reset (async assert): state IDLE; busy, hdr_valid, tvalid, tlast, tuser = 0; frames_sent, beats_sent = 0. Mid-frame reset drops valids immediately; no frame completion.
- All outputs registered. start at cycle t → busy, hdr_valid at t+1.
- hdr fire at t → tvalid at t+1; one beat per cycle while tready=1; frame = LENGTH beats, min frame time 1+LENGTH cycles.
- tlast fire at t → frames_sent updated at t+1; gap 0: hdr_valid at t+1; gap G: hdr_valid at t+1+G; end of run: busy=0 at t+1.

## Structure
- Shared package test_pkg: state enum, default ETH_TYPE, default MAC constants (shared with test receiver).
- One sub-module natural: test_gap_timer (load/count-down, done pulse, GAP_WIDTH wide).

## Test plan
- limit=3, gap=0, LENGTH=4, ready always 1 → 3 headers, 12 beats tdata 0..11, tlast on 3,7,11, busy falls cycle after last fire, frames_sent=3.
- limit=2, gap=5 → exactly 5 idle cycles between tlast fire and next hdr_valid.
- Random tready/hdr_ready backpressure → tdata/tlast stable while stalled, no beats lost, pattern contiguous.
- limit=0, stop pulse mid-frame 2 → frame 2 completes (LENGTH beats), no header 3, frames_sent=2; stop on tlast-fire cycle behaves identically.
- start while busy, and rst_n asserted mid-payload → start ignored; on reset all valids 0 same cycle, counters 0, next run's tdata starts at 0.
- beats_sent preset near 2^32-1 (force) → wraps to 0, tdata continues 0xFF→0x00 with DATA_WIDTH=8.

Source files
------------

// File: rtl/test_pkg.sv
// Definitions shared by the test frame scheduler and the test receiver.
package test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_ETH_TYPE  = 16'h88B5;
  localparam logic [47:0] DEFAULT_LOCAL_MAC = 48'h02_00_00_00_00_00;
  localparam logic [47:0] DEFAULT_DST_MAC   = 48'h02_00_00_00_00_00;

endpackage

// File: rtl/test_gap_timer.sv
// Inter-frame gap timer: loaded at frame end, counts down while enabled,
// and flags done during the last counted cycle.
module test_gap_timer #(
  parameter int GAP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [GAP_WIDTH-1:0] i_load_val,
  input  logic                 i_en,
  output logic                 o_done
);

  logic [GAP_WIDTH-1:0] r_count;

  // Down-counter holding the remaining gap cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - GAP_WIDTH'(1);
    end
  end

  assign o_done = i_en && (r_count <= GAP_WIDTH'(1));

endmodule

// File: rtl/test_frame_scheduler.sv
// Sources back-to-back test Ethernet frames (constant header, counting payload)
// for a programmable number of frames with a programmable inter-frame gap.
module test_frame_scheduler
  import test_pkg::*;
#(
  parameter int          LENGTH     = 512,
  parameter logic [47:0] LOCAL_MAC  = DEFAULT_LOCAL_MAC,
  parameter logic [47:0] DST_MAC    = DEFAULT_DST_MAC,
  parameter logic [15:0] ETH_TYPE   = DEFAULT_ETH_TYPE,
  parameter int          DATA_WIDTH = 8,
  parameter int          GAP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           frame_limit,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  output logic                  busy,
  output logic [31:0]           frames_sent,
  output logic [31:0]           beats_sent,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser
);

  localparam int CW = $clog2(LENGTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_beat_cnt;
  logic [CW-1:0]        w_beat_cnt_next;
  logic [31:0]          r_limit;
  logic [GAP_WIDTH-1:0] r_gap;
  logic                 r_stop_pending;
  logic [31:0]          r_frames_sent;
  logic [31:0]          r_beats_sent;
  logic                 r_busy;
  logic                 r_hdr_valid;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic                 w_hdr_fire;
  logic                 w_beat_fire;
  logic                 w_last_fire;
  logic                 w_run_end;
  logic                 w_gap_done;

  assign w_hdr_fire  = r_hdr_valid && m_eth_hdr_ready;
  assign w_beat_fire = r_tvalid && m_eth_payload_axis_tready;
  assign w_last_fire = w_beat_fire && r_tlast;
  // A stop arriving on the tlast handshake itself still ends the run at this frame.
  assign w_run_end   = r_stop_pending || stop ||
                       ((r_limit != 32'd0) && ((r_frames_sent + 32'd1) == r_limit));

  test_gap_timer #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_last_fire),
    .i_load_val (r_gap),
    .i_en       (r_state == ST_GAP),
    .o_done     (w_gap_done)
  );

  // Next-state and per-frame beat counter.
  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_HDR;
        else       w_state_next = ST_IDLE;
      end
      ST_HDR: begin
        if (w_hdr_fire) begin
          w_state_next    = ST_PAYLOAD;
          w_beat_cnt_next = '0;
        end else begin
          w_state_next = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (w_last_fire) begin
          if (w_run_end)           w_state_next = ST_IDLE;
          else if (r_gap == '0)    w_state_next = ST_HDR;
          else                     w_state_next = ST_GAP;
        end else if (w_beat_fire) begin
          w_beat_cnt_next = r_beat_cnt + CW'(1);
        end else begin
          w_state_next = ST_PAYLOAD;
        end
      end
      ST_GAP: begin
        if (w_gap_done) w_state_next = ST_HDR;
        else            w_state_next = ST_GAP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and handshake outputs decoded one cycle ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_beat_cnt  <= w_beat_cnt_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_hdr_valid <= (w_state_next == ST_HDR);
      r_tvalid    <= (w_state_next == ST_PAYLOAD);
      r_tlast     <= (w_state_next == ST_PAYLOAD) && (w_beat_cnt_next == CW'(LENGTH - 1));
    end
  end

  // Run settings, stop request and progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_limit        <= 32'd0;
      r_gap          <= '0;
      r_stop_pending <= 1'b0;
      r_frames_sent  <= 32'd0;
      r_beats_sent   <= 32'd0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_limit <= frame_limit;
        r_gap   <= gap_cycles;
      end
      if (r_state == ST_IDLE)  r_stop_pending <= 1'b0;
      else if (stop)           r_stop_pending <= 1'b1;
      if ((r_state == ST_IDLE) && start) r_frames_sent <= 32'd0;
      else if (w_last_fire)              r_frames_sent <= r_frames_sent + 32'd1;
      if (w_beat_fire) r_beats_sent <= r_beats_sent + 32'd1;
    end
  end

  assign busy                      = r_busy;
  assign frames_sent               = r_frames_sent;
  assign beats_sent                = r_beats_sent;
  assign m_eth_hdr_valid           = r_hdr_valid;
  assign m_eth_dest_mac            = DST_MAC;
  assign m_eth_src_mac             = LOCAL_MAC;
  assign m_eth_type                = ETH_TYPE;
  assign m_eth_payload_axis_tdata  = r_beats_sent[DATA_WIDTH-1:0];
  assign m_eth_payload_axis_tvalid = r_tvalid;
  assign m_eth_payload_axis_tlast  = r_tlast;
  assign m_eth_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_test_frame_scheduler.sv
// Self-checking bench for test_frame_scheduler: scenario table plus hand-written
// reset / wrap sequences, checked against a beat-stream reference model.
module tb_test_frame_scheduler;

  localparam int LEN = 4;

  typedef struct {
    int unsigned limit;
    int unsigned gap;
    int          mode;   // 0 none, 1 stop mid frame 2, 2 stop on tlast of frame 2, 3 start while busy, 4 start+stop together
    bit          bp;
    int unsigned exp_frames;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [31:0] frame_limit;
  logic [15:0] gap_cycles;
  logic        busy;
  logic [31:0] frames_sent, beats_sent;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic        tready = 1'b1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          bp_en = 1'b0;
  int unsigned cur_gap = 0;

  logic [31:0] model_beat = 32'd0;
  int          frame_beat = 0;
  int          run_frames = 0, run_hdrs = 0, run_beats = 0;
  int          last_fire_cyc = 0;
  logic        prev_tv = 1'b0, prev_tr = 1'b0, prev_tl = 1'b0, prev_hv = 1'b0, prev_hr = 1'b0;
  logic [7:0]  prev_td = 8'd0;

  vec_t tbl[8];

  test_frame_scheduler #(
    .LENGTH     (LEN),
    .DATA_WIDTH (8),
    .GAP_WIDTH  (16)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start                     (start),
    .stop                      (stop),
    .frame_limit               (frame_limit),
    .gap_cycles                (gap_cycles),
    .busy                      (busy),
    .frames_sent               (frames_sent),
    .beats_sent                (beats_sent),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (dest_mac),
    .m_eth_src_mac             (src_mac),
    .m_eth_type                (eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink-side ready generation (random backpressure when enabled).
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      tready    = ($urandom_range(0, 3) != 0);
      hdr_ready = ($urandom_range(0, 2) != 0);
    end else begin
      tready    = 1'b1;
      hdr_ready = 1'b1;
    end
  end

  // Monitor + reference model: the payload is one contiguous counting stream,
  // cut into frames of LEN beats, with cur_gap idle cycles before each new header.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_beat = 32'd0;
      frame_beat = 0;
      prev_tv = 1'b0; prev_tr = 1'b0; prev_hv = 1'b0; prev_hr = 1'b0;
    end else begin
      if (prev_tv && !prev_tr)
        chk("payload_stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_tl, prev_td});
      if (prev_hv && !prev_hr)
        chk("hdr_stall_hold", hdr_valid, 1'b1);
      if (hdr_valid && !prev_hv && run_frames > 0)
        chk("gap_length", cyc - last_fire_cyc - 1, cur_gap);
      if (hdr_valid && hdr_ready) run_hdrs++;
      if (tvalid && tready) begin
        chk("tdata", tdata, model_beat[7:0]);
        chk("tlast", tlast, (frame_beat == LEN - 1));
        model_beat = model_beat + 32'd1;
        run_beats++;
        if (frame_beat == LEN - 1) begin
          frame_beat = 0;
          run_frames++;
          last_fire_cyc = cyc;
        end else begin
          frame_beat++;
        end
      end
      prev_tv = tvalid; prev_tr = tready; prev_tl = tlast; prev_td = tdata;
      prev_hv = hdr_valid; prev_hr = hdr_ready;
    end
  end

  task automatic run(input vec_t v);
    bit issued = 1'b0;
    bit done = 1'b0;
    cur_gap    = v.gap;
    bp_en      = v.bp;
    run_frames = 0;
    run_hdrs   = 0;
    run_beats  = 0;
    @(posedge clk); #1;
    frame_limit = v.limit;
    gap_cycles  = v.gap[15:0];
    start       = 1'b1;
    stop        = (v.mode == 4);
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_latency", {busy, hdr_valid}, 2'b11);
    for (int c = 0; c < 4000 && !done; c++) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        start = 1'b0;
        stop  = 1'b0;
        if (!issued) begin
          case (v.mode)
            1: if (tvalid && !tlast && frames_sent == 32'd1) begin stop = 1'b1; issued = 1'b1; end
            2: if (tvalid && tlast && frames_sent == 32'd1) begin stop = 1'b1; issued = 1'b1; end
            3: if (tvalid && frames_sent == 32'd0) begin
                 start = 1'b1; frame_limit = 32'd0; gap_cycles = 16'd9; issued = 1'b1;
               end
            default: ;
          endcase
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    bp_en = 1'b0;
    chk("run_terminates", done, 1'b1);
    chk("busy_fall", cyc, last_fire_cyc + 1);
    chk("frames_sent", frames_sent, v.exp_frames);
    chk("hdr_count", run_hdrs, v.exp_frames);
    chk("beat_count", run_beats, v.exp_frames * LEN);
    chk("beats_sent", beats_sent, model_beat);
  endtask

  initial begin
    bit found;
    vec_t post;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; frame_limit = 32'd0; gap_cycles = 16'd0;
    tbl[0] = '{3, 0, 0, 1'b0, 3};
    tbl[1] = '{2, 5, 0, 1'b0, 2};
    tbl[2] = '{4, 2, 0, 1'b1, 4};
    tbl[3] = '{0, 0, 1, 1'b0, 2};
    tbl[4] = '{0, 3, 2, 1'b0, 2};
    tbl[5] = '{2, 0, 3, 1'b0, 2};
    tbl[6] = '{2, 1, 4, 1'b0, 2};
    tbl[7] = '{5, 1, 0, 1'b1, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, hdr_valid, tvalid, tlast, tuser, frames_sent, beats_sent}, 64'd0);
    rst_n = 1'b1;
    chk("header_fields", {dest_mac, src_mac, eth_type, tuser},
        {48'h02_00_00_00_00_00, 48'h02_00_00_00_00_00, 16'h88B5, 1'b0});

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Unlimited run: start while busy is ignored, then reset mid-payload.
    @(posedge clk); #1;
    run_frames = 0; cur_gap = 0;
    frame_limit = 32'd0; gap_cycles = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (tvalid && frames_sent == 32'd1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("reach_frame2", found, 1'b1);
    start = 1'b1; frame_limit = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_while_busy", {busy, frames_sent}, {1'b1, 32'd1});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, hdr_valid, tvalid, tlast, frames_sent, beats_sent}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    post = '{1, 0, 0, 1'b0, 1};
    run(post);

    // Counter wrap: tdata continues FF -> 00.
    @(posedge clk); #1;
    force dut.r_beats_sent = 32'hFFFF_FFFA;
    @(posedge clk); #1;
    release dut.r_beats_sent;
    model_beat = 32'hFFFF_FFFA;
    post = '{3, 0, 0, 1'b0, 3};
    run(post);
    chk("beats_wrap", beats_sent, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
